uart_tx: RTL and testbench

UART transmitter: serialises bytes onto a single line as 8N1 frames (start bit, 8 data bits LSB first, stop bit).
- Bytes enter through a valid/ready handshake into a small internal FIFO, so a host can queue several bytes without waiting for each frame.
- Pairs with the team's UART receiver on the FPGA-to-PC link (50 MHz system clock, 115200 baud default).

---
 rtl/uart_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_tx.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames fed from a small byte FIFO through a valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_TX_Serial,
    output logic       o_TX_Active,
    output logic       o_TX_Done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
`ifdef UART_TX_PARITY_EN
        PARITY_BIT,
`endif
        STOP_BIT,
        CLEANUP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          wr_en, pop;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic          serial_q, serial_n;
    logic          active_q, active_n;
    logic          done_q, done_n;
    logic [7:0]    data_q;

    // Full is judged from the registered count only, so a pop on the same edge never frees a slot early.
    assign o_TX_Ready  = (count < (AW+1)'(FIFO_DEPTH)) && !rst;
    assign wr_en       = i_TX_DV && o_TX_Ready;
    assign o_TX_Serial = serial_q;
    assign o_TX_Active = active_q;
    assign o_TX_Done   = done_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= i_TX_Byte;
        if (pop)   data_q      <= mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            serial_q <= serial_n;
            active_q <= active_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        serial_n = serial_q;
        active_n = active_q;
        done_n   = done_q;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                serial_n = 1'b1;
                cnt_n    = '0;
                idx_n    = '0;
                if (count != '0) begin
                    pop      = 1'b1;
                    serial_n = 1'b0;
                    active_n = 1'b1;
                    state_n  = START_BIT;
                end
            end
            START_BIT: begin
                if (cnt == CNT_MAX) begin
                    cnt_n    = '0;
                    serial_n = data_q[0];
                    state_n  = DATA_BITS;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA_BITS: begin
                if (cnt == CNT_MAX) begin
                    cnt_n = '0;
                    if (idx == 3'd7) begin
                        idx_n = '0;
`ifdef UART_TX_PARITY_EN
                        serial_n = ^data_q;
                        state_n  = PARITY_BIT;
`else
                        serial_n = 1'b1;
                        state_n  = STOP_BIT;
`endif
                    end else begin
                        idx_n    = idx + 3'd1;
                        serial_n = data_q[idx + 3'd1];
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: begin
                if (cnt == CNT_MAX) begin
                    cnt_n    = '0;
                    serial_n = 1'b1;
                    state_n  = STOP_BIT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`endif
            STOP_BIT: begin
                if (cnt == CNT_MAX) begin
                    cnt_n    = '0;
                    done_n   = 1'b1;
                    active_n = 1'b0;
                    state_n  = CLEANUP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            CLEANUP: begin
                done_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: random and directed bytes compared against a frame-level model.
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME_CYC = FB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_TX_DV = 1'b0;
    logic [7:0] i_TX_Byte = 8'h00;
    logic       o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] tx_q[$];

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_TX_DV(i_TX_DV), .i_TX_Byte(i_TX_Byte),
        .o_TX_Ready(o_TX_Ready), .o_TX_Serial(o_TX_Serial),
        .o_TX_Active(o_TX_Active), .o_TX_Done(o_TX_Done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected line levels for one frame, index 0 = start bit.
    function automatic logic [FB-1:0] exp_frame(input logic [7:0] d);
        logic [FB-1:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9]  = ^d;
        f[10] = 1'b1;
`else
        f[9] = 1'b1;
`endif
        return f;
    endfunction

    // Waits for a falling line, then records each bit level, stability and the Active/Done framing.
    task automatic capture_frame(input int max_wait, output int fall_cyc, output logic [FB-1:0] lvl,
                                 output bit stable, output bit act_ok, output bit done_ok, output bit found);
        found = 0; stable = 1; act_ok = 1; done_ok = 1; lvl = '0; fall_cyc = -1;
        for (int w = 0; w < max_wait; w++) begin
            @(negedge clk);
            if (o_TX_Serial === 1'b0) begin
                found = 1;
                break;
            end
        end
        if (!found) return;
        fall_cyc = cyc;
        for (int b = 0; b < FB; b++) begin
            for (int s = 0; s < CPB; s++) begin
                if (!(b == 0 && s == 0)) @(negedge clk);
                if (s == 0) lvl[b] = o_TX_Serial;
                else if (o_TX_Serial !== lvl[b]) stable = 0;
                if (o_TX_Active !== 1'b1 || o_TX_Done !== 1'b0) act_ok = 0;
            end
        end
        @(negedge clk);
        if (o_TX_Done !== 1'b1 || o_TX_Active !== 1'b0 || o_TX_Serial !== 1'b1) done_ok = 0;
        @(negedge clk);
        if (o_TX_Done !== 1'b0) done_ok = 0;
    endtask

    task automatic send_queue(output int first_edge);
        bit first = 1;
        first_edge = -1;
        while (tx_q.size() > 0) begin
            @(negedge clk);
            i_TX_DV   = 1'b1;
            i_TX_Byte = tx_q.pop_front();
            @(posedge clk);
            #1;
            if (first) first_edge = cyc;
            first = 0;
        end
        @(negedge clk);
        i_TX_DV = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (o_TX_Serial !== 1'b1 || o_TX_Active !== 1'b0 || o_TX_Done !== 1'b0 || o_TX_Ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: serial=%b active=%b done=%b ready=%b, want 1 0 0 0",
                         i, o_TX_Serial, o_TX_Active, o_TX_Done, o_TX_Ready);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_TX_Ready !== 1'b1 || o_TX_Serial !== 1'b1 || o_TX_Active !== 1'b0 || o_TX_Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b serial=%b active=%b done=%b, want 1 1 0 0",
                     o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] d;
        int wedge, fall;
        logic [FB-1:0] lvl;
        bit st, ao, dn, fnd;
        for (int k = 0; k < 5; k++) begin
            d = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            tx_q.push_back(d);
            send_queue(wedge);
            capture_frame(20, fall, lvl, st, ao, dn, fnd);
            checks++;
            if (!fnd || lvl !== exp_frame(d) || !st) begin
                errors++;
                $display("FAIL single_bits byte=%h: got levels=%b stable=%0d found=%0d, want %b",
                         d, lvl, st, fnd, exp_frame(d));
            end
            checks++;
            if (fall !== wedge + 1) begin
                errors++;
                $display("FAIL single_latency byte=%h: line fell at %0d, want %0d", d, fall, wedge + 1);
            end
            checks++;
            if (!ao || !dn) begin
                errors++;
                $display("FAIL single_framing byte=%h: active_ok=%0d done_ok=%0d, want 1 1", d, ao, dn);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [6];
        int wedge, prev, fall;
        logic [FB-1:0] lvl;
        bit st, ao, dn, fnd;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
        for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom_range(0, 255));
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 3; i++) tx_q.push_back(bytes[3*g+i]);
            prev = -1;
            fork
                send_queue(wedge);
                begin
                    for (int i = 0; i < 3; i++) begin
                        capture_frame(60, fall, lvl, st, ao, dn, fnd);
                        checks++;
                        if (!fnd || lvl !== exp_frame(bytes[3*g+i]) || !st || !ao || !dn) begin
                            errors++;
                            $display("FAIL b2b_frame%0d byte=%h: levels=%b st=%0d act=%0d done=%0d found=%0d, want %b",
                                     i, bytes[3*g+i], lvl, st, ao, dn, fnd, exp_frame(bytes[3*g+i]));
                        end
                        if (i > 0) begin
                            checks++;
                            if (fall - prev !== FRAME_CYC + 2) begin
                                errors++;
                                $display("FAIL b2b_spacing%0d: %0d cycles, want %0d", i, fall - prev, FRAME_CYC + 2);
                            end
                        end
                        prev = fall;
                    end
                end
            join
        end
    endtask

    task automatic test_fifo_full();
        bit exp_rdy [6] = '{1, 1, 1, 1, 1, 0};
        int n0, fall;
        logic [FB-1:0] lvl;
        bit st, ao, dn, fnd;
        n0 = -1;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    checks++;
                    if (o_TX_Ready !== exp_rdy[k]) begin
                        errors++;
                        $display("FAIL full_ready_w%0d: ready=%b, want %b", k, o_TX_Ready, exp_rdy[k]);
                    end
                    i_TX_DV   = 1'b1;
                    i_TX_Byte = 8'(k + 1);
                    @(posedge clk);
                    #1;
                    if (k == 0) n0 = cyc;
                end
                @(negedge clk);
                i_TX_DV = 1'b0;
                while (cyc < n0 + FRAME_CYC + 2) @(negedge clk);
                checks++;
                if (o_TX_Ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_ready_before_pop: ready=%b, want 0", o_TX_Ready);
                end
                @(negedge clk);
                checks++;
                if (o_TX_Ready !== 1'b1) begin
                    errors++;
                    $display("FAIL full_ready_after_pop: ready=%b, want 1", o_TX_Ready);
                end
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    capture_frame(60, fall, lvl, st, ao, dn, fnd);
                    checks++;
                    if (!fnd || lvl !== exp_frame(8'(i + 1)) || !st || !ao || !dn) begin
                        errors++;
                        $display("FAIL full_frame%0d: levels=%b st=%0d act=%0d done=%0d found=%0d, want %b",
                                 i, lvl, st, ao, dn, fnd, exp_frame(8'(i + 1)));
                    end
                end
                capture_frame(60, fall, lvl, st, ao, dn, fnd);
                checks++;
                if (fnd) begin
                    errors++;
                    $display("FAIL full_no_extra: extra frame levels=%b, want none", lvl);
                end
            end
        join
    endtask

    task automatic test_reset_mid_frame();
        int wedge, f0;
        bit bad;
        tx_q.push_back(8'h55); tx_q.push_back(8'h11); tx_q.push_back(8'h22);
        send_queue(wedge);
        f0 = wedge + 1;
        while (cyc < f0 + 4*CPB + 1) @(negedge clk);
        checks++;
        if (o_TX_Serial !== 1'b0 || o_TX_Active !== 1'b1) begin
            errors++;
            $display("FAIL mid_before_rst: serial=%b active=%b, want 0 1", o_TX_Serial, o_TX_Active);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (o_TX_Serial !== 1'b1 || o_TX_Active !== 1'b0 || o_TX_Done !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_rst: serial=%b active=%b done=%b, want 1 0 0", o_TX_Serial, o_TX_Active, o_TX_Done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (o_TX_Serial !== 1'b1 || o_TX_Active !== 1'b0 || o_TX_Done !== 1'b0 || o_TX_Ready !== 1'b1) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL mid_after_release: activity seen after reset (bad=%0d), want idle line", bad);
        end
    endtask

    task automatic test_parity();
        logic [7:0] d;
        int wedge, fall;
        logic [FB-1:0] lvl;
        bit st, ao, dn, fnd;
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? 8'h07 : 8'h03;
            tx_q.push_back(d);
            send_queue(wedge);
            capture_frame(20, fall, lvl, st, ao, dn, fnd);
            checks++;
            if (!fnd || lvl !== exp_frame(d) || !st || !ao || !dn) begin
                errors++;
                $display("FAIL parity_frame byte=%h: levels=%b st=%0d act=%0d done=%0d, want %b",
                         d, lvl, st, ao, dn, exp_frame(d));
            end
`ifdef UART_TX_PARITY_EN
            checks++;
            if (lvl[9] !== ((k == 0) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL parity_bit byte=%h: got %b, want %b", d, lvl[9], (k == 0) ? 1'b1 : 1'b0);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_frame();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
